debounce_edge_detect: RTL and testbench
=======================================

Name: debounce_edge_detect

Overview:
- Sits directly downstream of the two-flop input synchronizer (sync_high / sync_low) and consumes its sync_out.
- Rejects glitches shorter than STABLE_CYCLES clock edges and publishes a debounced level.
- Emits one-cycle rise/fall pulses on each accepted transition, for use by control FSMs and counters further downstream.

Parameters:
- STABLE_CYCLES, 4, consecutive sampling edges sync_in must differ from level_out before the change is accepted; legal range 1..255.
- RESET_LEVEL, 1'b1, value of level_out after reset; matches the idle value of the upstream synchronizer.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- sync_in  input  1  synchronized input from the synchronizer stage.
- level_out  output  1  debounced level; registered.
- rise_pulse  output  1  one-cycle pulse when level_out goes 0->1; registered.
- fall_pulse  output  1  one-cycle pulse when level_out goes 1->0; registered.
- pending  output  1  high while a candidate change is being qualified; registered.

Behaviour:
- Reset:
  - Sampled only at a rising clk edge with n_rst=0; no asynchronous path.
  - Resulting state: level_out=RESET_LEVEL, rise_pulse=0, fall_pulse=0, pending=0, counter=0, FSM=STABLE.
- FSM states: STABLE, CANDIDATE.
- STABLE:
  - sync_in==level_out: hold, counter=0.
  - sync_in!=level_out and STABLE_CYCLES>1: go CANDIDATE, counter=1, pending=1.
  - sync_in!=level_out and STABLE_CYCLES==1: accept immediately (see Accept).
- CANDIDATE:
  - sync_in==level_out: glitch rejected. Go STABLE, counter=0, pending=0, no pulse.
  - sync_in!=level_out and counter==STABLE_CYCLES-1: accept.
  - Otherwise: counter+1, stay CANDIDATE.
- Accept (same edge):
  - level_out<=sync_in.
  - Pulse matching the new level asserted for exactly the following cycle.
  - FSM returns to STABLE with counter=0 and pending=0.
- Latency:
  - sync_in stable at the new value from edge e1 onward: level_out and pulse change at edge e(STABLE_CYCLES).
  - Pulses drop at the next edge.
- Pulses:
  - Never both high in the same cycle.
  - Default 0 every cycle unless an accept occurs.
- Counter:
  - Width $clog2(STABLE_CYCLES+1).
  - Never exceeds STABLE_CYCLES-1; no wrap-around.
- Back-to-back changes: a reversal sampled on the edge right after an accept starts a fresh candidate (counter=1). Minimum pulse spacing is STABLE_CYCLES cycles.
- Reset mid-candidate: abandons qualification. No pulse; level_out forced to RESET_LEVEL even if the candidate matched it.
- Reset has priority over all other transitions at the same edge.
- X on sync_in: behaviour unspecified. The bench only checks that outputs are not X once sync_in is 0/1 for STABLE_CYCLES edges after reset.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic {STABLE, CANDIDATE} deb_state_t.
  - localparam DEB_MAX_CYCLES=255 (used by an elaboration-time range check).
- Sub-module stable_counter, parameter NUM_CNT_BITS:
  - Inputs: clear, count_enable, terminal value.
  - Output: at_terminal flag.
  - Synchronous active-low reset.
- debounce_edge_detect holds the FSM, level register and pulse registers.

Test Plan:
1. Apply reset: n_rst=0 for 2 edges with sync_in=0 -> after first reset edge level_out=1, rise=fall=pending=0; still 1/0/0/0 after release with sync_in=1.
2. Accepted fall: STABLE_CYCLES=4, level 1. Drive sync_in=0 at negedge, hold -> pending=1 after e1; level_out=0 and fall_pulse=1 after e4; fall_pulse=0 after e5; rise_pulse never high.
3. Glitch reject: sync_in=0 for 3 edges, then 1 -> pending 1,1,1 then 0; level_out stays 1; no pulses.
4. Accepted rise: from level 0, sync_in=1 held 4 edges -> level_out=1 and rise_pulse=1 for one cycle after e4. Immediate reversal to 0 after e4 -> pending=1 after e5, fall_pulse after e8.
5. Reset mid-candidate: sync_in=0 for 2 edges, then n_rst=0 for 1 edge -> pending=0, level_out=1, no fall_pulse. After release with sync_in still 0, fall accepted 4 edges later.
6. STABLE_CYCLES=1 instance: toggle sync_in 1->0->1 each held 1 edge -> level_out follows with 1-edge latency; fall_pulse then rise_pulse each 1 cycle; pending never high.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce / edge-detect block.
package debounce_pkg;

  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } deb_state_t;

  localparam int DEB_MAX_CYCLES = 255;

endpackage

// File: rtl/debounce_edge_detect_stable_counter.sv
// Qualification counter: counts consecutive edges on which the input disagrees
// with the published level, and flags when the accept threshold is reached.
module stable_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] terminal,
  output logic                    at_terminal
);

  logic [NUM_CNT_BITS-1:0] count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= count + NUM_CNT_BITS'(1);
    end
  end

  // The owner never enables counting at terminal, so there is no wrap-around.
  assign at_terminal = (count == terminal);

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronized input and emits one-cycle rise/fall pulses on
// every accepted transition of the debounced level.
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sync_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic pending
);

  localparam int CNT_BITS = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] TERMINAL = CNT_BITS'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > DEB_MAX_CYCLES) begin : g_bad_stable_cycles
    $error("debounce_edge_detect: STABLE_CYCLES out of range 1..255");
  end

  deb_state_t state;
  logic       differ;
  logic       at_terminal;
  logic       accept;
  logic       cnt_clear;
  logic       cnt_enable;

  // The counter holds how many edges have already disagreed; in STABLE it is 0,
  // so an accept from STABLE only happens when the threshold is a single edge.
  assign differ     = (sync_in != level_out);
  assign accept     = differ && at_terminal;
  assign cnt_clear  = !differ || accept;
  assign cnt_enable = differ && !at_terminal;

  stable_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_stable_counter (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (cnt_clear),
    .count_enable(cnt_enable),
    .terminal    (TERMINAL),
    .at_terminal (at_terminal)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= STABLE;
      level_out  <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      pending    <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (accept) begin
        level_out  <= sync_in;
        rise_pulse <= sync_in;
        fall_pulse <= !sync_in;
        state      <= STABLE;
        pending    <= 1'b0;
      end else begin
        case (state)
          STABLE: begin
            if (differ) begin
              state   <= CANDIDATE;
              pending <= 1'b1;
            end
          end
          CANDIDATE: begin
            if (!differ) begin
              state   <= STABLE;
              pending <= 1'b0;
            end
          end
          default: begin
            state   <= STABLE;
            pending <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: a 4-edge and a 1-edge instance share stimulus
// and are checked every cycle against a run-length model of the debounce rule.
module tb_debounce_edge_detect;

  logic       clk;
  logic       n_rst;
  logic       sync_in;
  logic [1:0] level_o;
  logic [1:0] rise_o;
  logic [1:0] fall_o;
  logic [1:0] pend_o;

  int n_compared;
  int n_mismatched;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  debounce_edge_detect #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) u_dut4 (
    .clk       (clk),
    .n_rst     (n_rst),
    .sync_in   (sync_in),
    .level_out (level_o[0]),
    .rise_pulse(rise_o[0]),
    .fall_pulse(fall_o[0]),
    .pending   (pend_o[0])
  );

  debounce_edge_detect #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) u_dut1 (
    .clk       (clk),
    .n_rst     (n_rst),
    .sync_in   (sync_in),
    .level_out (level_o[1]),
    .rise_pulse(rise_o[1]),
    .fall_pulse(fall_o[1]),
    .pending   (pend_o[1])
  );

  // Behavioural model: a change is accepted once sync_in has disagreed with the
  // published level on SC consecutive edges; pending means a nonzero run.
  int   sc_of [2] = '{4, 1};
  int   m_run [2];
  logic m_level [2];
  logic m_rise [2];
  logic m_fall [2];
  logic m_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   run;
      logic lvl;
      logic r;
      logic f;
      run = m_run[i];
      lvl = m_level[i];
      r   = 1'b0;
      f   = 1'b0;
      if (!n_rst) begin
        run = 0;
        lvl = 1'b1;
      end else if (sync_in !== lvl) begin
        run = run + 1;
        if (run >= sc_of[i]) begin
          lvl = sync_in;
          r   = sync_in;
          f   = ~sync_in;
          run = 0;
        end
      end else begin
        run = 0;
      end
      m_run[i]   <= run;
      m_level[i] <= lvl;
      m_rise[i]  <= r;
      m_fall[i]  <= f;
    end
    if (!n_rst) m_valid <= 1'b1;
  end

  // scoreboard: expected values for one instance pushed into a queue, then popped
  logic [3:0] exp_q[$];

  task automatic check(input string name, input int inst, input logic act, input logic exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s[sc=%0d] t=%0t: got %b expected %b", name, sc_of[inst], $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        exp_q.push_back({m_level[i], m_rise[i], m_fall[i], (m_run[i] != 0)});
        begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("level_out",  i, level_o[i], e[3]);
          check("rise_pulse", i, rise_o[i],  e[2]);
          check("fall_pulse", i, fall_o[i],  e[1]);
          check("pending",    i, pend_o[i],  e[0]);
          check("pulse_excl", i, rise_o[i] & fall_o[i], 1'b0);
        end
      end
    end
  end

  // driver tasks: called at a negedge, return at the following negedge
  task automatic cyc(input logic s, input logic r);
    sync_in = s;
    n_rst   = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycn(input logic s, input int n);
    for (int k = 0; k < n; k++) cyc(s, 1'b1);
  endtask

  // literal expectation on both the DUT and the model for one instance
  task automatic lit(input string tag, input int i, input logic l, input logic r,
                     input logic f, input logic p);
    check({tag, ".level"}, i, level_o[i], l);
    check({tag, ".rise"},  i, rise_o[i],  r);
    check({tag, ".fall"},  i, fall_o[i],  f);
    check({tag, ".pend"},  i, pend_o[i],  p);
    check({tag, ".model_level"}, i, m_level[i], l);
    check({tag, ".model_pend"},  i, (m_run[i] != 0), p);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    sync_in      = 1'b0;
    n_rst        = 1'b0;
    @(negedge clk);

    // reset with sync_in=0, then release with sync_in=1
    lit("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    lit("reset2", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("reset2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    lit("release", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // accepted fall, 4-edge latency
    cyc(1'b0, 1'b1);
    lit("fall_e1", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    lit("sc1_fall", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycn(1'b0, 2);
    lit("fall_e3", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    lit("fall_e4", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    lit("fall_e5", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // accepted rise followed by an immediate reversal
    cycn(1'b1, 3);
    lit("rise_e3", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    lit("rise_e4", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    lit("rev_e5", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycn(1'b0, 2);
    cyc(1'b0, 1'b1);
    lit("rev_e8", 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // back to level 1, then a 3-edge glitch is rejected
    cycn(1'b1, 4);
    lit("rise2", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycn(1'b0, 3);
    lit("glitch3", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    lit("glitch_rej", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a candidate, then the fall re-qualifies from scratch
    cycn(1'b0, 2);
    lit("mid_cand", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    lit("mid_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("mid_reset", 1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycn(1'b0, 3);
    lit("requal_e3", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    lit("requal_e4", 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // single-edge instance follows each toggle with one edge of latency
    cyc(1'b1, 1'b1);
    lit("sc1_r", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    lit("sc1_f", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    lit("sc1_r2", 1, 1'b1, 1'b1, 1'b0, 1'b0);

    // randomized runs of varying length with occasional resets
    for (int k = 0; k < 600; k++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        cyc(v, ($urandom_range(0, 149) != 0));
      end
    end

    cycn(1'b1, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
